// File: rtl/intel_fpga_led_driver.sv
// Multi-channel LED driver: off / on / shared-phase blink / pulse-stretch per channel.
// Optional PWM dimming with per-channel brightness when INTEL_FPGA_LED_DRIVER_PWM_EN is defined.
module intel_fpga_led_driver #(
    parameter int unsigned P_CLK_FREQ_HZ   = 20_000_000,
    parameter int unsigned P_NUM_CHANNELS  = 1,
    parameter int unsigned P_BLINK_HALF_MS = 250,
    parameter int unsigned P_STRETCH_MS    = 100
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [2*P_NUM_CHANNELS-1:0]   i_mode,
    input  logic [P_NUM_CHANNELS-1:0]     i_trig,
`ifdef INTEL_FPGA_LED_DRIVER_PWM_EN
    input  logic [8*P_NUM_CHANNELS-1:0]   i_bright,
`endif
    output logic [P_NUM_CHANNELS-1:0]     o_led
);

    localparam int unsigned PS_LIMIT_INT = P_CLK_FREQ_HZ / 1000 - 1;
    localparam int unsigned PS_W         = $clog2(PS_LIMIT_INT) + 1;
    localparam int unsigned MS_W         = $clog2(P_BLINK_HALF_MS) + 1;
    localparam int unsigned ST_W         = $clog2(P_STRETCH_MS) + 1;

    localparam logic [PS_W-1:0] PS_LIMIT = PS_W'(PS_LIMIT_INT);
    localparam logic [MS_W-1:0] MS_LAST  = MS_W'(P_BLINK_HALF_MS - 1);
    localparam logic [ST_W-1:0] ST_LOAD  = ST_W'(P_STRETCH_MS);

    localparam logic [1:0] MODE_OFF     = 2'b00;
    localparam logic [1:0] MODE_ON      = 2'b01;
    localparam logic [1:0] MODE_BLINK   = 2'b10;
    localparam logic [1:0] MODE_STRETCH = 2'b11;

    // 1 ms tick prescaler
    logic [PS_W-1:0] ps_q, ps_d;
    logic            tick;

    assign tick = (ps_q == '0);

    always_comb begin
        ps_d = tick ? PS_LIMIT : ps_q - PS_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ps_q <= PS_LIMIT;
        end else begin
            ps_q <= ps_d;
        end
    end

    // Shared blink timebase keeps every blinking channel phase-aligned
    logic [MS_W-1:0] ms_q, ms_d;
    logic            phase_q, phase_d;

    always_comb begin
        ms_d    = ms_q;
        phase_d = phase_q;
        if (tick) begin
            if (ms_q == MS_LAST) begin
                ms_d    = '0;
                phase_d = ~phase_q;
            end else begin
                ms_d = ms_q + MS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ms_q    <= '0;
            phase_q <= 1'b0;
        end else begin
            ms_q    <= ms_d;
            phase_q <= phase_d;
        end
    end

    // History resets high so a trigger already asserted out of reset is not an edge
    logic [P_NUM_CHANNELS-1:0] trig_prev_q;
    logic [P_NUM_CHANNELS-1:0] trig_rise;

    assign trig_rise = i_trig & ~trig_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trig_prev_q <= '1;
        end else begin
            trig_prev_q <= i_trig;
        end
    end

    // Per-channel stretch counters, in ms
    logic [ST_W-1:0] stretch_q [P_NUM_CHANNELS];
    logic [ST_W-1:0] stretch_d [P_NUM_CHANNELS];

    always_comb begin
        for (int unsigned ch = 0; ch < P_NUM_CHANNELS; ch++) begin
            stretch_d[ch] = stretch_q[ch];
            if (i_mode[2*ch +: 2] != MODE_STRETCH) begin
                stretch_d[ch] = '0;
            end else if (trig_rise[ch]) begin
                // Load wins over a coincident tick so the pulse is never shortened
                stretch_d[ch] = ST_LOAD;
            end else if (tick && (stretch_q[ch] != '0)) begin
                stretch_d[ch] = stretch_q[ch] - ST_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned ch = 0; ch < P_NUM_CHANNELS; ch++) begin
            if (rst) begin
                stretch_q[ch] <= '0;
            end else begin
                stretch_q[ch] <= stretch_d[ch];
            end
        end
    end

    // On-request decode
    logic [P_NUM_CHANNELS-1:0] on_req;

    always_comb begin
        for (int unsigned ch = 0; ch < P_NUM_CHANNELS; ch++) begin
            on_req[ch] = 1'b0;
            unique case (i_mode[2*ch +: 2])
                MODE_OFF:     on_req[ch] = 1'b0;
                MODE_ON:      on_req[ch] = 1'b1;
                MODE_BLINK:   on_req[ch] = phase_q;
                MODE_STRETCH: on_req[ch] = (stretch_q[ch] != '0);
                default:      on_req[ch] = 1'b0;
            endcase
        end
    end

    logic [P_NUM_CHANNELS-1:0] led_d;

`ifdef INTEL_FPGA_LED_DRIVER_PWM_EN
    logic [7:0] pwm_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_q <= '0;
        end else begin
            pwm_q <= pwm_q + 8'd1;
        end
    end

    // Strict compare: brightness 0 never lights, 255 lights 255 of 256 cycles
    always_comb begin
        for (int unsigned ch = 0; ch < P_NUM_CHANNELS; ch++) begin
            led_d[ch] = on_req[ch] & (pwm_q < i_bright[8*ch +: 8]);
        end
    end
`else
    always_comb begin
        led_d = on_req;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            o_led <= '0;
        end else begin
            o_led <= led_d;
        end
    end

endmodule
